// File: rtl/seg7_scan_driver_if.sv
// Bundles the value/control inputs and display outputs of seg7_scan_driver.
// The master side drives value and controls; the slave side is the driver itself.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 2,
    parameter int VAL_W  = 7
);
    logic [VAL_W-1:0]  value;
    logic              load;
    logic              blank_lz;
    logic              blink_en;
    logic              busy;
    logic              ovf;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (
        output value, load, blank_lz, blink_en,
        input  busy, ovf, seg, an
    );

    modport slave (
        input  value, load, blank_lz, blink_en,
        output busy, ovf, seg, an
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-seg scan driver: binary capture, serial double-dabble to BCD, digit multiplexing.
// Latency: VAL_W cycles from load edge to new BCD, seg/an registered one cycle behind scan index.
// Backpressure: load is ignored while busy; no queueing.
module seg7_scan_driver #(
    parameter int DIGITS     = 2,
    parameter int VAL_W      = 7,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 500000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    seg7_scan_driver_if.slave bus
);
    localparam int BCD_W   = 4 * DIGITS;
    localparam int STEP_W  = $clog2(VAL_W + 1);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] OVF_LIM = 32'(10 ** DIGITS);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t             r_state, w_state_nxt;
    logic               w_start, w_done;
    logic [VAL_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_work, w_adj, w_work_nxt;
    logic [STEP_W-1:0]  r_step;
    logic               r_ovf_pend;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic               w_allz, w_blank;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg_raw, r_seg;
    logic [DIGITS-1:0]  w_an_raw, r_an;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 7'b0111111;
            4'd1:    dec7 = 7'b0000110;
            4'd2:    dec7 = 7'b1011011;
            4'd3:    dec7 = 7'b1001111;
            4'd4:    dec7 = 7'b1100110;
            4'd5:    dec7 = 7'b1101101;
            4'd6:    dec7 = 7'b1111101;
            4'd7:    dec7 = 7'b0000111;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1101111;
            default: dec7 = 7'b0000000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (bus.load) begin
                w_start     = 1'b1;
                w_state_nxt = S_CONV;
            end
            S_CONV: if (r_step == STEP_W'(VAL_W - 1)) begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >=5, then shift in the next value MSB.
    always_comb begin
        w_adj = r_work;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_work[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
        end
        w_work_nxt = {w_adj[BCD_W-2:0], r_shift[VAL_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_work     <= '0;
            r_step     <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else if (w_start) begin
            r_shift    <= bus.value;
            r_work     <= '0;
            r_step     <= '0;
            r_ovf_pend <= (32'(bus.value) >= OVF_LIM);
        end else if (r_state == S_CONV) begin
            r_shift <= r_shift << 1;
            r_work  <= w_work_nxt;
            r_step  <= r_step + STEP_W'(1);
            if (w_done) begin
                r_bcd <= w_work_nxt;
                r_ovf <= r_ovf_pend;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Walk from the top digit down so w_allz means "this and all higher nibbles are zero".
    always_comb begin
        w_allz  = 1'b1;
        w_nib   = 4'd0;
        w_blank = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_allz = w_allz & (r_bcd[4*k +: 4] == 4'd0);
            if (r_idx == IDX_W'(k)) begin
                w_nib   = r_bcd[4*k +: 4];
                w_blank = (k != 0) && w_allz;
            end
        end
        if (r_ovf)                        w_seg_raw = 7'b1000000;
        else if (bus.blank_lz && w_blank) w_seg_raw = 7'b0000000;
        else                              w_seg_raw = dec7(w_nib);
        w_an_raw = DIGITS'(1) << r_idx;
        if (bus.blink_en && !r_blink_on) w_an_raw = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= {7{ACTIVE_LOW}};
            r_an  <= {DIGITS{ACTIVE_LOW}};
        end else begin
            r_seg <= w_seg_raw ^ {7{ACTIVE_LOW}};
            r_an  <= w_an_raw ^ {DIGITS{ACTIVE_LOW}};
        end
    end

    assign bus.busy = (r_state == S_CONV);
    assign bus.ovf  = r_ovf;
    assign bus.seg  = r_seg;
    assign bus.an   = r_an;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: conversion latency, scan, blanking, overflow, reset abort, blink.
module tb_seg7_scan_driver;
    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    seg7_scan_driver_if #(.DIGITS(2), .VAL_W(7)) bus ();
    seg7_scan_driver_if #(.DIGITS(2), .VAL_W(7)) bus_al ();

    seg7_scan_driver #(
        .DIGITS(2), .VAL_W(7), .SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seg7_scan_driver #(
        .DIGITS(2), .VAL_W(7), .SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk (clk),
        .rst (rst),
        .bus (bus_al.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [6:0] v, output int busy_cycles);
        bus.value = v;
        bus.load  = 1'b1;
        tick();
        bus.load    = 1'b0;
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 50) begin
            busy_cycles++;
            tick();
        end
    endtask

    // Eight consecutive samples cover one full scan period: each digit exactly 4 cycles.
    task automatic check_scan(input string tag, input logic [6:0] e0, input logic [6:0] e1);
        int n01;
        n01 = 0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            if (bus.an == 2'b01) begin
                n01++;
                chk({tag, "_d0"}, bus.seg, e0);
            end else if (bus.an == 2'b10) begin
                chk({tag, "_d1"}, bus.seg, e1);
            end else begin
                chk({tag, "_an"}, bus.an, 2'b01);
            end
            tick();
        end
        chk({tag, "_dwell"}, n01, 4);
    endtask

    initial begin
        int bc;
        int found, on_run, off_run, seg_ok;
        logic [1:0] prev_an;

        rst = 1'b1;
        bus.value = '0;    bus.load = 1'b0;    bus.blank_lz = 1'b0;    bus.blink_en = 1'b0;
        bus_al.value = '0; bus_al.load = 1'b0; bus_al.blank_lz = 1'b0; bus_al.blink_en = 1'b0;

        repeat (3) tick();
        chk("rst_seg", bus.seg, 7'b0000000);
        chk("rst_an", bus.an, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ovf", bus.ovf, 1'b0);
        chk("rst_al_seg", bus_al.seg, 7'b1111111);
        chk("rst_al_an", bus_al.an, 2'b11);
        rst = 1'b0;

        repeat (3) tick();
        chk("al_zero_seg", bus_al.seg, 7'b1000000);
        chk("al_an_onehot", (bus_al.an == 2'b01) || (bus_al.an == 2'b10), 1'b1);

        do_load(7'd42, bc);
        chk("busy42", bc, 7);
        check_scan("v42", 7'b1011011, 7'b1100110);

        bus.blank_lz = 1'b1;
        do_load(7'd5, bc);
        chk("busy5", bc, 7);
        check_scan("v5lz", 7'b1101101, 7'b0000000);
        do_load(7'd0, bc);
        check_scan("v0lz", 7'b0111111, 7'b0000000);

        do_load(7'd100, bc);
        chk("ovf100", bus.ovf, 1'b1);
        check_scan("v100", 7'b1000000, 7'b1000000);
        do_load(7'd99, bc);
        chk("ovf99", bus.ovf, 1'b0);
        check_scan("v99", 7'b1101111, 7'b1101111);
        bus.blank_lz = 1'b0;

        bus.value = 7'd42;
        bus.load  = 1'b1;
        tick();
        bus.load = 1'b0;
        bc = 0;
        if (bus.busy) bc++;
        tick();
        if (bus.busy) bc++;
        bus.value = 7'd17;
        bus.load  = 1'b1;
        tick();
        bus.load = 1'b0;
        if (bus.busy) bc++;
        while (bus.busy && bc < 50) begin
            tick();
            if (bus.busy) bc++;
        end
        chk("busy_ignore", bc, 7);
        check_scan("ign17", 7'b1011011, 7'b1100110);

        bus.value = 7'd55;
        bus.load  = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_seg", bus.seg, 7'b0000000);
        chk("abort_an", bus.an, 2'b00);
        chk("abort_ovf", bus.ovf, 1'b0);
        check_scan("abort_bcd", 7'b0111111, 7'b0111111);
        do_load(7'd73, bc);
        chk("busy73", bc, 7);
        check_scan("v73", 7'b1001111, 7'b0000111);

        do_load(7'd42, bc);
        bus.blink_en = 1'b1;
        found   = 0;
        prev_an = bus.an;
        for (int i = 0; i < 80 && found == 0; i++) begin
            tick();
            if (prev_an == 2'b00 && bus.an != 2'b00) found = 1;
            prev_an = bus.an;
        end
        chk("blink_sync", found, 1);
        on_run = 1;
        tick();
        while (bus.an != 2'b00 && on_run < 40) begin
            on_run++;
            tick();
        end
        chk("blink_on_len", on_run, 16);
        off_run = 0;
        seg_ok  = 1;
        while (bus.an == 2'b00 && off_run < 40) begin
            off_run++;
            if (bus.seg != 7'b1011011 && bus.seg != 7'b1100110) seg_ok = 0;
            tick();
        end
        chk("blink_off_len", off_run, 16);
        chk("blink_seg", seg_ok, 1);
        bus.blink_en = 1'b0;
        check_scan("unblink", 7'b1011011, 7'b1100110);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multi-digit seven-segment driver for the traffic-light timer display. It captures a binary time value and converts it to BCD with a sequential shift-add-3 engine. It then time-multiplexes the digits onto one shared segment bus. It adds leading-zero blanking, overflow indication, blinking and output polarity selection, none of which the single-digit combinational decoder has.

Parameters:
DIGITS, 2, number of digits (1..8); an[0] is the least-significant digit
VAL_W, 7, width of binary input value (1..27)
SCAN_DIV, 1000, clk cycles each digit is shown (>=2)
BLINK_DIV, 500000, clk cycles per blink half-period (>=2)
ACTIVE_LOW, 0, 1 = seg and an driven active-low (common-anode boards)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
value  in  VAL_W  unsigned binary value to display
load  in  1  capture request for value; honoured only when busy=0
blank_lz  in  1  1 = blank leading zero digits
blink_en  in  1  1 = flash whole display at BLINK_DIV rate
busy  out  1  conversion in progress
ovf  out  1  displayed value >= 10**DIGITS
seg  out  7  segments, bit0=a .. bit6=g (registered)
an  out  DIGITS  one-hot digit enable (registered)

Behaviour:
- Reset (rst=1 at an edge): busy=0, ovf=0, displayed BCD=all zero, scan index=0, scan and blink counters=0, blink phase=on. seg=all off and an=all inactive, i.e. 0 for ACTIVE_LOW=0 and all ones for ACTIVE_LOW=1. Reset mid-conversion aborts it and discards the partial result.
- Capture: load=1 with busy=0 at edge N latches value. ovf_pending=(value >= 10**DIGITS). busy=1 after edge N. load while busy=1 is ignored, with no queueing.
- Conversion: double-dabble over VAL_W edges. Each step adds 3 to every BCD nibble >=5, then shifts left by one bit, bringing in the next value MSB. The BCD register is 4*DIGITS bits wide. At edge N+VAL_W the displayed BCD and ovf update atomically and busy falls. The display never shows a partial result. Total latency from the load edge to the new display is VAL_W cycles.
- Scan: the counter runs 0..SCAN_DIV-1. On wrap, the index advances modulo DIGITS, wrapping from DIGITS-1 to 0. seg and an reflect the current index one cycle after the index changes. Scanning runs continuously, including while busy.
- Decode (before polarity): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. A nibble >9 is not reachable when ovf=0; it must decode to all off.
- Leading-zero blanking: when blank_lz=1, digit k>0 shows all off if it and every more-significant nibble are zero. Digit 0 is never blanked. The anode still cycles normally.
- Overflow: when ovf=1, every digit shows 1000000 (dash) and blanking is ignored.
- Blink: the blink counter runs 0..BLINK_DIV-1 continuously and toggles the phase on wrap. When blink_en=1 and phase=off, an is all inactive. seg keeps normal decode. When blink_en=0, an is unaffected.
- Polarity: when ACTIVE_LOW=1, the final seg and an are bitwise inverted after all of the above.
- Simultaneous events: the conversion-done update and a scan step on the same edge both take effect. The next registered seg uses the new BCD.

Test Plan:
(DIGITS=2, VAL_W=7, SCAN_DIV=4, BLINK_DIV=16, ACTIVE_LOW=0 unless noted)
1. Reset held 3 cycles -> seg=0000000, an=00, busy=0, ovf=0. With ACTIVE_LOW=1 -> seg=1111111, an=11.
2. load value=42 -> busy=1 for exactly 7 cycles. The display then alternates an=01 seg=1011011 ("2") and an=10 seg=1100110 ("4"), each for 4 cycles.
3. value=5, blank_lz=1 -> an=10 shows seg=0000000 and an=01 shows 1101101. value=0 -> digit0 shows 0111111 and digit1 is blank.
4. value=100 -> ovf=1 and both digits show 1000000. Then value=99 -> ovf=0, and 1101111 is shown on both digits.
5. load 42, then load 17 two cycles later (busy) -> 17 is ignored and 42 is displayed. rst asserted at cycle 3 of a conversion -> busy=0 and display returns to the reset state. The next load converts correctly.
6. blink_en=1 with value 42 -> an=00 for 16 cycles, then normal scanning for 16 cycles, repeating. seg is unaffected.
